apbgpu_cmdq: RTL and testbench

APBGPU_CMDQ -- requirements
Module: apbgpu_cmdq

---
 rtl/apbgpu_cmdq.sv | 163 ++++++++++++++++
 tb/tb_apbgpu_cmdq.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apbgpu_cmdq.sv
// apbgpu_cmdq: APB-programmed command queue feeding a GPU core.
//
// Software pushes {opcode, parameters} commands through the CMD register.
// They are held in a DEPTH-entry FIFO and presented to the GPU core one at a
// time on a valid/ready handshake. STATUS reports occupancy and a sticky
// overflow flag. CTRL can flush the queue and clear the overflow flag.
//
// Ports
//   clk, n_rst             clock, asynchronous active-low reset
//   pAddr_i .. pWrite_i    APB requester side (address bits [3:2] pick the register)
//   pReady_o               APB ready; low only while a CMD write waits on a full queue
//   pDataRead_o            APB read data (zero outside ACCESS reads)
//   pSlvErr_o              APB error, only ever high in ACCESS
//   command_o              head command valid towards the GPU core
//   cmd_ready_i            GPU core takes the head command
//   opcode_o               head command opcode (zero when empty)
//   parameters_o           head command parameters (zero when empty)
module apbgpu_cmdq #(
  parameter int DEPTH         = 8,
  parameter int PARW          = 25,
  parameter int STALL_ON_FULL = 1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [31:0]     pAddr_i,
  input  logic [31:0]     pDataWrite_i,
  input  logic            pSel_i,
  input  logic            pEnable_i,
  input  logic            pWrite_i,
  output logic            pReady_o,
  output logic [31:0]     pDataRead_o,
  output logic            pSlvErr_o,
  output logic            command_o,
  input  logic            cmd_ready_i,
  output logic [3:0]      opcode_o,
  output logic [PARW-1:0] parameters_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 + PARW;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            access;
  logic [1:0]      reg_sel;
  logic            empty;
  logic            full;
  logic            pop;
  logic            cmd_wr;
  logic            ctrl_wr;
  logic            stall;
  logic            drop;
  logic            push;
  logic            flush;
  logic            clr_ovf;
  logic            bad_access;
  logic [EW-1:0]   head;
  logic [EW-1:0]   push_data;
  logic [31:0]     status;
  logic            unused_ok;

  // Address bits outside [3:2] and write-data bits [27:PARW] carry no meaning.
  assign unused_ok = ^{pAddr_i[31:4], pAddr_i[1:0], pDataWrite_i};

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign command_o = !empty;
  assign pop       = command_o && cmd_ready_i;

  // Head comes from storage only, so a push never falls through in its own cycle.
  assign head         = mem_q[rd_ptr_q];
  assign opcode_o     = empty ? 4'd0 : head[EW-1 -: 4];
  assign parameters_o = empty ? '0 : head[PARW-1:0];

  // An access only counts while the requester keeps the transfer alive.
  assign access  = (state_q == ACCESS) && pSel_i && pEnable_i;
  assign reg_sel = pAddr_i[3:2];
  assign cmd_wr  = access && pWrite_i && (reg_sel == 2'd0);
  assign ctrl_wr = access && pWrite_i && (reg_sel == 2'd2);

  // A same-cycle pop frees a slot, so a full queue only blocks without one.
  // pReady_o must see this cycle's pop, which is why it is combinational.
  assign stall    = cmd_wr && (STALL_ON_FULL != 0) && full && !pop;
  assign drop     = cmd_wr && (STALL_ON_FULL == 0) && full && !pop;
  assign pReady_o = !stall;
  assign push     = cmd_wr && (!full || pop);

  assign flush   = ctrl_wr && pDataWrite_i[0];
  assign clr_ovf = ctrl_wr && pDataWrite_i[1];

  assign push_data = {pDataWrite_i[31:28], pDataWrite_i[PARW-1:0]};

  assign bad_access = access && ((reg_sel == 2'd3) ||
                                 ((reg_sel == 2'd2) && !pWrite_i) ||
                                 ((reg_sel == 2'd1) && pWrite_i));
  assign pSlvErr_o  = bad_access || drop;

  assign status      = {overflow_q, 21'd0, full, empty, 8'(count_q)};
  assign pDataRead_o = (access && !pWrite_i && (reg_sel == 2'd1)) ? status : 32'd0;

  // Next-state: APB phase, FIFO pointers/count, sticky overflow.
  // A flush overrides any push or pop landing in the same cycle.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE:    if (pSel_i && !pEnable_i) state_d = ACCESS;
      ACCESS:  if (!access || pReady_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    if (clr_ovf)   overflow_d = 1'b0;
    else if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; only the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_apbgpu_cmdq.sv
// tb_apbgpu_cmdq: self-checking bench for apbgpu_cmdq.
//
// Two instances share clock and reset: unit 0 stalls APB when full, unit 1
// drops and flags. A queue-based model predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
module tb_apbgpu_cmdq;

  localparam int DEPTH = 8;
  localparam int PARW  = 25;

  logic        clk;
  logic        n_rst;
  logic [1:0]  pSel, pEnable, pWrite, cmdReady;
  logic [31:0] pAddr [2];
  logic [31:0] pWdata [2];
  logic [1:0]  pReady, pSlvErr, command;
  logic [31:0] pRdata [2];
  logic [3:0]  opcode [2];
  logic [24:0] params [2];

  int tests = 0;
  int fails = 0;

  // Model state: one queue per unit of {opcode, parameters}.
  logic [28:0] q0 [$];
  logic [28:0] q1 [$];
  logic [1:0]  mAccess;
  logic [1:0]  mOvf;

  logic [31:0] popped [$];
  int          maxSz;

  logic [31:0] fillData [9] = '{32'h0E000001, 32'h1E000004, 32'h2E000007,
                                32'h3E00000A, 32'h4E00000D, 32'h5FFFFFFF,
                                32'h6E000013, 32'h7E000016, 32'h8FFFFFFF};

  apbgpu_cmdq #(.DEPTH(DEPTH), .PARW(PARW), .STALL_ON_FULL(1)) u_stall (
    .clk(clk), .n_rst(n_rst),
    .pAddr_i(pAddr[0]), .pDataWrite_i(pWdata[0]),
    .pSel_i(pSel[0]), .pEnable_i(pEnable[0]), .pWrite_i(pWrite[0]),
    .pReady_o(pReady[0]), .pDataRead_o(pRdata[0]), .pSlvErr_o(pSlvErr[0]),
    .command_o(command[0]), .cmd_ready_i(cmdReady[0]),
    .opcode_o(opcode[0]), .parameters_o(params[0])
  );

  apbgpu_cmdq #(.DEPTH(DEPTH), .PARW(PARW), .STALL_ON_FULL(0)) u_drop (
    .clk(clk), .n_rst(n_rst),
    .pAddr_i(pAddr[1]), .pDataWrite_i(pWdata[1]),
    .pSel_i(pSel[1]), .pEnable_i(pEnable[1]), .pWrite_i(pWrite[1]),
    .pReady_o(pReady[1]), .pDataRead_o(pRdata[1]), .pSlvErr_o(pSlvErr[1]),
    .command_o(command[1]), .cmd_ready_i(cmdReady[1]),
    .opcode_o(opcode[1]), .parameters_o(params[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model helpers: queue access by unit and the expected output rules.
  function automatic bit stallMode(input int u);
    return (u == 0);
  endfunction

  function automatic int qSize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [28:0] qHead(input int u);
    if (qSize(u) == 0) return '0;
    return (u == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic accessNow(input int u);
    return mAccess[u] && pSel[u] && pEnable[u];
  endfunction

  function automatic logic popNow(input int u);
    return (qSize(u) > 0) && cmdReady[u];
  endfunction

  function automatic logic fullHit(input int u);
    return accessNow(u) && pWrite[u] && (pAddr[u][3:2] == 2'd0) &&
           (qSize(u) == DEPTH) && !popNow(u);
  endfunction

  function automatic logic expReady(input int u);
    return !(fullHit(u) && stallMode(u));
  endfunction

  function automatic logic expErr(input int u);
    logic [1:0] r;
    r = pAddr[u][3:2];
    return accessNow(u) && ((r == 2'd3) || ((r == 2'd2) && !pWrite[u]) ||
                            ((r == 2'd1) && pWrite[u]) || (fullHit(u) && !stallMode(u)));
  endfunction

  function automatic logic [31:0] statusWord(input int u);
    int n;
    n = qSize(u);
    return {mOvf[u], 21'd0, (n == DEPTH), (n == 0), 8'(n)};
  endfunction

  function automatic logic [31:0] expRdata(input int u);
    if (accessNow(u) && !pWrite[u] && (pAddr[u][3:2] == 2'd1)) return statusWord(u);
    return 32'd0;
  endfunction

  function automatic logic [31:0] expEntry(input logic [31:0] d);
    return {3'd0, d[31:28], d[24:0]};
  endfunction

  // Advance the model by one clock edge for one unit.
  task automatic modelStep(input int u);
    logic acc, rdy, pop, full, push, flush, clr, setOvf;
    logic [28:0] e;
    acc    = accessNow(u);
    rdy    = expReady(u);
    pop    = popNow(u);
    full   = (qSize(u) == DEPTH);
    push   = 1'b0;
    flush  = 1'b0;
    clr    = 1'b0;
    setOvf = 1'b0;
    e      = {pWdata[u][31:28], pWdata[u][24:0]};
    if (acc && rdy && pWrite[u]) begin
      if (pAddr[u][3:2] == 2'd0) begin
        if (!full || pop) push = 1'b1;
        else setOvf = 1'b1;
      end else if (pAddr[u][3:2] == 2'd2) begin
        flush = pWdata[u][0];
        clr   = pWdata[u][1];
      end
    end
    if (flush) begin
      if (u == 0) q0.delete(); else q1.delete();
    end else begin
      if (pop) begin
        if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (push) begin
        if (u == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    if (clr) mOvf[u] = 1'b0;
    if (setOvf) mOvf[u] = 1'b1;
    mAccess[u] = mAccess[u] ? (acc && !rdy) : (pSel[u] && !pEnable[u]);
  endtask

  initial begin
    mAccess = '0;
    mOvf    = '0;
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) begin
        q0.delete();
        q1.delete();
        mAccess = '0;
        mOvf    = '0;
      end else begin
        for (int u = 0; u < 2; u++) modelStep(u);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both units against the model.
  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (n_rst) begin
        for (int u = 0; u < 2; u++) begin
          logic [28:0] h;
          h = qHead(u);
          checkOutput($sformatf("u%0d pReady_o", u), {31'd0, pReady[u]}, {31'd0, expReady(u)});
          checkOutput($sformatf("u%0d pSlvErr_o", u), {31'd0, pSlvErr[u]}, {31'd0, expErr(u)});
          checkOutput($sformatf("u%0d pDataRead_o", u), pRdata[u], expRdata(u));
          checkOutput($sformatf("u%0d command_o", u), {31'd0, command[u]}, {31'd0, (qSize(u) != 0)});
          checkOutput($sformatf("u%0d opcode_o", u), {28'd0, opcode[u]}, {28'd0, h[28:25]});
          checkOutput($sformatf("u%0d parameters_o", u), {7'd0, params[u]}, {7'd0, h[24:0]});
        end
        if (command[0] && cmdReady[0]) popped.push_back({3'd0, opcode[0], params[0]});
        if (q0.size() > maxSz) maxSz = q0.size();
      end
    end
  endtask

  // One complete APB transfer; optionally raises cmd_ready after N wait states.
  task automatic applyStimulus(input int u, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int releaseAfter,
                               output logic [31:0] rdata, output logic err, output int stalls);
    bit   done;
    logic rdy;
    @(posedge clk); #1;
    pSel[u] = 1'b1; pEnable[u] = 1'b0; pWrite[u] = wr; pAddr[u] = addr; pWdata[u] = wdata;
    @(posedge clk); #1;
    pEnable[u] = 1'b1;
    stalls = 0;
    done   = 1'b0;
    rdata  = '0;
    err    = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      rdy   = pReady[u];
      rdata = pRdata[u];
      err   = pSlvErr[u];
      if (!rdy) stalls++;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
      else if (releaseAfter > 0 && stalls == releaseAfter) cmdReady[u] = 1'b1;
    end
    if (releaseAfter > 0) cmdReady[u] = 1'b0;
    pSel[u] = 1'b0; pEnable[u] = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL apb timeout u%0d: got no pReady, expected pReady within 64 cycles", u);
    end
  endtask

  task automatic readStatus(input int u, input string name, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          st;
    applyStimulus(u, 1'b0, 32'h4, 32'h0, 0, rd, er, st);
    checkOutput(name, rd, exp);
  endtask

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          st;

    n_rst = 1'b0;
    pSel = '0; pEnable = '0; pWrite = '0; cmdReady = '0;
    for (int u = 0; u < 2; u++) begin
      pAddr[u] = '0;
      pWdata[u] = '0;
    end
    maxSz = 0;
    fork
      compareLoop();
    join_none

    #2;
    checkOutput("reset pReady_o", {31'd0, pReady[0]}, 32'd1);
    checkOutput("reset command_o", {31'd0, command[0]}, 32'd0);
    checkOutput("reset pDataRead_o", pRdata[0], 32'd0);
    checkOutput("reset pSlvErr_o", {31'd0, pSlvErr[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // Single push: visible the cycle after, masked fields as specified.
    applyStimulus(0, 1'b1, 32'h0, 32'hA0000123, 0, rd, er, st);
    @(negedge clk);
    checkOutput("push command_o", {31'd0, command[0]}, 32'd1);
    checkOutput("push opcode_o", {28'd0, opcode[0]}, 32'hA);
    checkOutput("push parameters_o", {7'd0, params[0]}, 32'h0000123);
    readStatus(0, "push status", 32'h00000001);
    applyStimulus(0, 1'b1, 32'h8, 32'h1, 0, rd, er, st);
    readStatus(0, "flush status", 32'h00000100);

    // Back-to-back pushes drained as they arrive.
    popped.delete();
    maxSz = 0;
    cmdReady[0] = 1'b1;
    applyStimulus(0, 1'b1, 32'h0, 32'h10000001, 0, rd, er, st);
    applyStimulus(0, 1'b1, 32'h0, 32'h2A000002, 0, rd, er, st);
    applyStimulus(0, 1'b1, 32'h0, 32'h30000003, 0, rd, er, st);
    repeat (2) @(posedge clk);
    #1 cmdReady[0] = 1'b0;
    checkOutput("stream pop count", popped.size(), 32'd3);
    if (popped.size() == 3) begin
      checkOutput("stream pop0", popped[0], 32'h02000001);
      checkOutput("stream pop1", popped[1], 32'h04000002);
      checkOutput("stream pop2", popped[2], 32'h06000003);
    end
    checkOutput("stream max count", {31'd0, (maxSz <= 1)}, 32'd1);
    @(negedge clk);
    checkOutput("stream command_o", {31'd0, command[0]}, 32'd0);
    readStatus(0, "stream status", 32'h00000100);

    // Fill, stall the ninth write for 5 cycles, then drain in order.
    popped.delete();
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 32'h0, fillData[i], 0, rd, er, st);
    applyStimulus(0, 1'b1, 32'h0, fillData[8], 5, rd, er, st);
    checkOutput("stall cycles", st, 32'd5);
    checkOutput("stall pSlvErr_o", {31'd0, er}, 32'd0);
    readStatus(0, "stall status", 32'h00000208);
    cmdReady[0] = 1'b1;
    repeat (12) @(posedge clk);
    #1 cmdReady[0] = 1'b0;
    checkOutput("drain pop count", popped.size(), 32'd9);
    for (int i = 0; i < 9 && i < popped.size(); i++)
      checkOutput($sformatf("drain pop%0d", i), popped[i], expEntry(fillData[i]));
    readStatus(0, "drain status", 32'h00000100);

    // Flush with entries queued, then register-map error cases.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 32'h0, fillData[i], 0, rd, er, st);
    applyStimulus(0, 1'b1, 32'h8, 32'h1, 0, rd, er, st);
    @(negedge clk);
    checkOutput("flush5 command_o", {31'd0, command[0]}, 32'd0);
    readStatus(0, "flush5 status", 32'h00000100);
    applyStimulus(0, 1'b0, 32'hC, 32'h0, 0, rd, er, st);
    checkOutput("unmapped err", {31'd0, er}, 32'd1);
    checkOutput("unmapped rdata", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'h8, 32'h0, 0, rd, er, st);
    checkOutput("ctrl read err", {31'd0, er}, 32'd1);
    applyStimulus(0, 1'b1, 32'h4, 32'hFFFFFFFF, 0, rd, er, st);
    checkOutput("status write err", {31'd0, er}, 32'd1);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 0, rd, er, st);
    checkOutput("cmd read err", {31'd0, er}, 32'd0);
    checkOutput("cmd read rdata", rd, 32'd0);

    // Transfer abandoned in ACCESS must not push.
    @(posedge clk); #1;
    pSel[0] = 1'b1; pEnable[0] = 1'b0; pWrite[0] = 1'b1; pAddr[0] = 32'h0; pWdata[0] = 32'h70000001;
    @(posedge clk); #1;
    pSel[0] = 1'b0; pEnable[0] = 1'b1;
    @(posedge clk); #1;
    pEnable[0] = 1'b0;
    readStatus(0, "dropped status", 32'h00000100);

    // Drop-on-full unit: overflow flagged, then cleared.
    for (int i = 0; i < 8; i++) applyStimulus(1, 1'b1, 32'h0, fillData[i], 0, rd, er, st);
    checkOutput("drop 8th err", {31'd0, er}, 32'd0);
    applyStimulus(1, 1'b1, 32'h0, fillData[8], 0, rd, er, st);
    checkOutput("drop 9th err", {31'd0, er}, 32'd1);
    checkOutput("drop 9th stalls", st, 32'd0);
    readStatus(1, "drop status", 32'h80000208);
    applyStimulus(1, 1'b1, 32'h8, 32'h2, 0, rd, er, st);
    readStatus(1, "clear ovf status", 32'h00000208);
    @(negedge clk);
    checkOutput("drop head opcode_o", {28'd0, opcode[1]}, 32'h0);
    checkOutput("drop head parameters_o", {7'd0, params[1]}, 32'h0000001);

    // Reset during a stalled write.
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 32'h0, fillData[i], 0, rd, er, st);
    @(posedge clk); #1;
    pSel[0] = 1'b1; pEnable[0] = 1'b0; pWrite[0] = 1'b1; pAddr[0] = 32'h0; pWdata[0] = 32'h9000000F;
    @(posedge clk); #1;
    pEnable[0] = 1'b1;
    @(negedge clk);
    checkOutput("prereset pReady_o", {31'd0, pReady[0]}, 32'd0);
    @(posedge clk); #3;
    n_rst = 1'b0;
    #1;
    checkOutput("async pReady_o", {31'd0, pReady[0]}, 32'd1);
    checkOutput("async command_o", {31'd0, command[0]}, 32'd0);
    checkOutput("async opcode_o", {28'd0, opcode[0]}, 32'd0);
    checkOutput("async parameters_o", {7'd0, params[0]}, 32'd0);
    checkOutput("async pSlvErr_o", {31'd0, pSlvErr[0]}, 32'd0);
    checkOutput("async pDataRead_o", pRdata[0], 32'd0);
    checkOutput("async u1 command_o", {31'd0, command[1]}, 32'd0);
    pSel[0] = 1'b0; pEnable[0] = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    readStatus(0, "post reset status", 32'h00000100);
    readStatus(1, "post reset u1 status", 32'h00000100);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
